bram_uart_dump: RTL and testbench
=================================

# bram_uart_dump

Streams a contiguous run of 8-bit audio samples out of the audio BRAM read port and over the UART line to the host PC, one 8N1 frame per sample. It is the playback-to-PC counterpart of the UART-RX-to-BRAM capture path. It sits in the top level between the BRAM read port (owning addr/dout) and the FPGA-to-computer UART pin.

## Interface
- INPUT_CLOCK_FREQ, 100_000_000: clk_in frequency in Hz
- BAUD_RATE, 115_200: line rate; BAUD_DIV = INPUT_CLOCK_FREQ / BAUD_RATE, integer truncation (868)
- RAM_DEPTH, 40_000: BRAM depth in samples
- ADDR_WIDTH, $clog2(RAM_DEPTH): address width
- READ_LATENCY, 2: BRAM address-to-dout latency in cycles (1 or 2)

- clk_in  input  1  system clock; only clock in the block
- rst_in  input  1  asynchronous, active-low reset (0 = reset)
- start_in  input  1  single-cycle request; sampled only in IDLE
- abort_in  input  1  finish the current frame, then stop
- len_in  input  ADDR_WIDTH+1  number of samples; sampled with start_in
- bram_addr_out  output  ADDR_WIDTH  read address to BRAM
- bram_data_in  input  8  BRAM dout
- busy_out  output  1  high while a dump is in progress
- done_out  output  1  one-cycle pulse at end of dump
- tx_wire_out  output  1  UART serial line, idle high

## Operation
- FSM states: IDLE, FETCH, SEND, FINISH.
- IDLE: on start_in, latch len = min(len_in, RAM_DEPTH) and set addr = 0. If len == 0, go to FINISH. Otherwise go to FETCH.
- FETCH: drive addr. Wait READ_LATENCY cycles, then capture bram_data_in into the TX shift register and go to SEND.
- SEND: the TX core emits the frame LSB-first: start bit 0, d0..d7, stop bit 1, each held BAUD_DIV cycles.
- At the end of the stop bit:
  - if addr == len-1, or abort is pending, go to FINISH;
  - otherwise addr += 1 and go to FETCH.
- FINISH: done_out = 1 for one cycle, busy_out = 0, then return to IDLE.
- abort_in is latched as pending in any non-IDLE state. It never truncates a frame. abort_in in IDLE is ignored.
- start_in outside IDLE is ignored.
- Asynchronous reset, applied at any time:
  - state = IDLE, addr = 0;
  - tx_wire_out = 1 immediately, with no glitch low;
  - busy_out = 0, done_out = 0, pending abort cleared.
  - A frame in flight is dropped.

## Timing
- Reset values: tx_wire_out 1, busy_out 0, done_out 0, bram_addr_out 0.
- start_in high at edge k (len ≥ 1) gives:
  - busy_out = 1 and bram_addr_out = 0 from k+1;
  - data captured at edge k+1+READ_LATENCY;
  - tx_wire_out falls at k+2+READ_LATENCY.
- Frame length: exactly 10·BAUD_DIV cycles (8680).
- Between frames: line held high READ_LATENCY+1 cycles after the stop bit before the next start bit. Address increments on the cycle after the stop bit ends.
- done_out pulses on the cycle after the last stop bit ends. busy_out falls on that same cycle.
- len_in = 0: done_out pulses at k+1; busy_out stays 0; tx_wire_out stays 1.
- Registered outputs only; tx_wire_out comes straight from a flop.

## Structure
- Shared package audio_pkg holds:
  - the state enum (IDLE/FETCH/SEND/FINISH);
  - the default BRAM_WIDTH = 8 and RAM_DEPTH = 40_000;
  - a baud-divisor function.
- Sub-module uart_tx_core holds the baud counter, bit index, 10-bit shift register and tx_wire_out.
  - Inputs: load strobe and byte.
  - Outputs: frame_done pulse and line.
- bram_uart_dump keeps the FSM, address counter, length clamp and abort latch.

## Test plan
- Dump of 3 bytes:
  - Stimulus: BRAM[0..2] = 0xA5, 0x00, 0xFF; len = 3; start.
  - Required: three frames decode to 0xA5, 0x00, 0xFF; each bit 868 cycles; start bit at k+4; one done_out pulse; exactly 3 address values 0, 1, 2.
- len_in = 0 -> done_out at k+1; tx_wire_out constant 1; busy_out never high.
- start_in pulsed mid-frame of a len = 2 dump -> ignored; exactly 2 frames sent; a single done_out.
- abort_in pulsed during the second frame of a len = 10 dump -> second frame completes intact; done_out follows its stop bit; only 2 frames total.
- rst_in low during the bit 3 window of the first frame:
  - tx_wire_out = 1, busy_out = 0, bram_addr_out = 0 in the same cycle;
  - after release, a fresh start dumps correctly.
- Length clamp:
  - Setup: RAM_DEPTH = 16, READ_LATENCY = 1, BAUD_DIV overridden small.
  - Stimulus: len_in = 20.
  - Required: exactly 16 frames from addresses 0..15, then done_out.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants
// for the audio BRAM / UART datapath.
package audio_pkg;

  localparam int BRAM_WIDTH    = 8;
  localparam int RAM_DEPTH_DEF = 40_000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FINISH
  } dump_state_e;

  function automatic int baud_div(
    input int clk_hz,
    input int baud
  );
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 transmitter, LSB first.
// The line comes straight from tx_q.
module uart_tx_core #(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       frame_done_o,
  output logic       tx_o
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(BAUD_DIV - 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;
  logic [9:0]    shift_q;
  logic          tx_q;
  logic          bit_end;

  assign bit_end = active_q &&
                   (cnt_q == CNT_MAX);

  // Combinational so the sequencer can act
  // on the very edge the stop bit ends.
  assign frame_done_o = bit_end &&
                        (bit_q == 4'd9);
  assign tx_o = tx_q;

  // Bit timing: shift_q[0] is the bit on the line, tx_q mirrors it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      tx_q     <= 1'b1;
    end else if (load_i && !active_q) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, data_i, 1'b0};
      tx_q     <= 1'b0;
    end else if (bit_end) begin
      cnt_q <= '0;
      if (bit_q == 4'd9) begin
        active_q <= 1'b0;
      end else begin
        tx_q    <= shift_q[1];
        shift_q <= {1'b1, shift_q[9:1]};
        bit_q   <= bit_q + 4'd1;
      end
    end else if (active_q) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/bram_uart_dump.sv
// bram_uart_dump: streams BRAM samples
// out over UART, one 8N1 frame each.
module bram_uart_dump
  import audio_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int RAM_DEPTH        = RAM_DEPTH_DEF,
  parameter int ADDR_WIDTH       = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY     = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  abort_in,
  input  logic [ADDR_WIDTH:0]   len_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [BRAM_WIDTH-1:0] bram_data_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  tx_wire_out
);

  localparam int BAUD_DIV =
    baud_div(INPUT_CLOCK_FREQ, BAUD_RATE);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE =
    (ADDR_WIDTH + 1)'(1);
  localparam logic [1:0] LAT =
    2'(READ_LATENCY);

  dump_state_e           state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   len_clamp;
  logic [1:0]            wait_q;
  logic                  abort_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  load;
  logic                  frame_done;
  logic                  last;

  assign len_clamp = (len_in > DEPTH) ?
                     DEPTH : len_in;

  // wait_q reaches LAT on the edge where
  // dout belongs to the current addr_q.
  assign load = (state_q == FETCH) &&
                (wait_q == LAT);

  assign last = ({1'b0, addr_q} ==
                 (len_q - ONE));

  assign bram_addr_out = addr_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;

  uart_tx_core #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load_i       (load),
    .data_i       (bram_data_in),
    .frame_done_o (frame_done),
    .tx_o         (tx_wire_out)
  );

  // Dump sequencer: fetch, send, repeat until last sample or abort.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          abort_q <= 1'b0;
          if (start_in) begin
            len_q  <= len_clamp;
            addr_q <= '0;
            wait_q <= '0;
            if (len_clamp == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
            end
          end
        end
        FETCH: begin
          abort_q <= abort_q | abort_in;
          if (load) begin
            state_q <= SEND;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        SEND: begin
          abort_q <= abort_q | abort_in;
          if (frame_done) begin
            if (last || abort_q || abort_in) begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
              addr_q  <= addr_q + ADDR_WIDTH'(1);
              wait_q  <= '0;
            end
          end
        end
        FINISH: begin
          abort_q <= abort_q | abort_in;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_uart_dump.sv
// tb_bram_uart_dump: random BRAM dumps
// checked by a UART frame scoreboard.
`timescale 1ns/1ps
module tb_bram_uart_dump;

  // Bit periods follow clk/baud, truncated.
  localparam int DA   = 1_000_000 / 62_500;
  localparam int DB   = 1_000_000 / 190_000;
  localparam int RLA  = 2;
  localparam int RLB  = 1;
  localparam int DEPA = 40_000;
  localparam int DEPB = 16;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        startA, abortA;
  logic [16:0] lenA;
  logic [15:0] addrA;
  logic [7:0]  dinA;
  logic        busyA, doneA, txA;

  logic        startB, abortB;
  logic [4:0]  lenB;
  logic [3:0]  addrB;
  logic [7:0]  dinB;
  logic        busyB, doneB, txB;

  bram_uart_dump #(
    .INPUT_CLOCK_FREQ (1_000_000),
    .BAUD_RATE        (62_500),
    .RAM_DEPTH        (DEPA),
    .READ_LATENCY     (RLA)
  ) u_a (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .start_in      (startA),
    .abort_in      (abortA),
    .len_in        (lenA),
    .bram_addr_out (addrA),
    .bram_data_in  (dinA),
    .busy_out      (busyA),
    .done_out      (doneA),
    .tx_wire_out   (txA)
  );

  bram_uart_dump #(
    .INPUT_CLOCK_FREQ (1_000_000),
    .BAUD_RATE        (190_000),
    .RAM_DEPTH        (DEPB),
    .READ_LATENCY     (RLB)
  ) u_b (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .start_in      (startB),
    .abort_in      (abortB),
    .len_in        (lenB),
    .bram_addr_out (addrB),
    .bram_data_in  (dinB),
    .busy_out      (busyB),
    .done_out      (doneB),
    .tx_wire_out   (txB)
  );

  // BRAM models: two-stage and one-stage read.
  logic [7:0] memA [64];
  logic [7:0] memB [16];
  logic [7:0] pipeA;
  always @(posedge clk) begin
    pipeA <= memA[addrA[5:0]];
    dinA  <= pipeA;
    dinB  <= memB[addrB];
  end

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  int   nframes[2] = '{0, 0};
  int   ndone[2]   = '{0, 0};
  int   nbusy[2]   = '{0, 0};

  task automatic chk(
    input string             nm,
    input logic signed [31:0] act,
    input logic signed [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, exp);
    end
  endtask

  function automatic logic busy_of(input int g);
    return (g == 0) ? busyA : busyB;
  endfunction

  function automatic logic done_of(input int g);
    return (g == 0) ? doneA : doneB;
  endfunction

  function automatic logic tx_of(input int g);
    return (g == 0) ? txA : txB;
  endfunction

  function automatic int addr_of(input int g);
    return (g == 0) ? int'(addrA) : int'(addrB);
  endfunction

  function automatic logic [7:0] mem_of(
    input int g,
    input int a
  );
    return (g == 0) ? memA[a[5:0]] : memB[a[3:0]];
  endfunction

  task automatic fill(input int g);
    for (int a = 0; a < 64; a++) begin
      if (g == 0) memA[a] = 8'($urandom);
      else if (a < 16) memB[a] = 8'($urandom);
    end
  endtask

  task automatic set_start(
    input int   g,
    input logic v,
    input int   len
  );
    if (g == 0) begin
      startA = v;
      lenA   = 17'(len);
    end else begin
      startB = v;
      lenB   = 5'(len);
    end
  endtask

  task automatic set_abort(
    input int   g,
    input logic v
  );
    if (g == 0) abortA = v;
    else abortB = v;
  endtask

  // Per-DUT monitors: frame decoder plus
  // done/busy cycle counters.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int D = (g == 0) ? DA : DB;

    always @(posedge clk) begin
      if (rst_n === 1'b1 && done_of(g) === 1'b1)
        ndone[g]++;
      if (rst_n === 1'b1 && busy_of(g) === 1'b1)
        nbusy[g]++;
    end

    initial begin : frame_mon
      exp_t       e;
      int         bad;
      int         a0;
      logic [7:0] got;
      bit         dropped;
      bit         have;
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && tx_of(g) === 1'b0) begin
          have = expq.size() > 0;
          e    = '{addr: 0, data: 8'h00};
          if (have) e = expq.pop_front();
          a0      = addr_of(g);
          bad     = 0;
          got     = 8'h00;
          dropped = 1'b0;
          for (int i = 0; i < 10 * D; i++) begin
            logic eb;
            if (i > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              dropped = 1'b1;
              break;
            end
            eb = (i < D)     ? 1'b0 :
                 (i >= 9 * D) ? 1'b1 :
                 e.data[(i / D) - 1];
            if (tx_of(g) !== eb) bad++;
            if (i >= D && i < 9 * D &&
                (i % D) == (D / 2))
              got[(i / D) - 1] = tx_of(g);
          end
          if (!dropped) begin
            nframes[g]++;
            chk("frame_expected", have, 1);
            if (have) begin
              chk("frame_data", got, e.data);
              chk("frame_bit_timing", bad, 0);
              chk("frame_addr", a0, e.addr);
            end
          end
        end
      end
    end
  end

  // One dump: extra 1 = stray start during
  // frame 1, extra 2 = abort during frame 2.
  task automatic dump(
    input int g,
    input int len,
    input int extra
  );
    int d, rl, dep, n, k;
    int f0, d0, b0, at, exp_at;
    d   = (g == 0) ? DA : DB;
    rl  = (g == 0) ? RLA : RLB;
    dep = (g == 0) ? DEPA : DEPB;
    n   = (len < dep) ? len : dep;
    if (extra == 2 && n > 2) n = 2;
    for (int a = 0; a < n; a++)
      expq.push_back('{addr: a, data: mem_of(g, a)});
    f0 = nframes[g];
    d0 = ndone[g];
    b0 = nbusy[g];
    @(negedge clk);
    set_start(g, 1'b1, len);
    k = cyc + 1;
    @(negedge clk);
    set_start(g, 1'b0, int'($urandom_range(0, 31)));
    chk("busy_after_start", busy_of(g), n > 0);
    chk("addr_after_start", addr_of(g), 0);
    if (n > 0) begin
      while (cyc < k + rl) @(negedge clk);
      chk("line_before_start_bit", tx_of(g), 1);
      @(negedge clk);
      chk("start_bit_edge", tx_of(g), 0);
    end
    if (extra == 1) begin
      while (cyc < k + 1 + rl + 3 * d)
        @(negedge clk);
      set_start(g, 1'b1, 7);
      @(negedge clk);
      set_start(g, 1'b0, 0);
    end else if (extra == 2) begin
      while (cyc < k + 2 * (1 + rl) + 13 * d)
        @(negedge clk);
      set_abort(g, 1'b1);
      @(negedge clk);
      set_abort(g, 1'b0);
    end
    exp_at = k + n * (10 * d + rl + 1);
    at = -1;
    for (int i = 0; i < 40_000 && at < 0; i++) begin
      if (done_of(g) === 1'b1) at = cyc;
      else @(negedge clk);
    end
    chk("done_cycle", at, exp_at);
    @(negedge clk);
    chk("done_one_cycle", done_of(g), 0);
    chk("busy_after_done", busy_of(g), 0);
    @(negedge clk);
    chk("frames_sent", nframes[g] - f0, n);
    chk("scoreboard_drained", expq.size(), 0);
    chk("done_pulses", ndone[g] - d0, 1);
    chk("busy_cycles", nbusy[g] - b0, exp_at - k);
    expq.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k;
    rst_n  = 1'b0;
    startA = 1'b0;
    abortA = 1'b0;
    lenA   = '0;
    startB = 1'b0;
    abortB = 1'b0;
    lenB   = '0;
    fill(0);
    fill(1);
    repeat (3) @(negedge clk);
    chk("reset_line_a", txA, 1);
    chk("reset_busy_a", busyA, 0);
    chk("reset_done_a", doneA, 0);
    chk("reset_addr_a", addrA, 0);
    chk("reset_line_b", txB, 1);
    chk("reset_busy_b", busyB, 0);
    chk("reset_done_b", doneB, 0);
    chk("reset_addr_b", addrB, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    memA[0] = 8'hA5;
    memA[1] = 8'h00;
    memA[2] = 8'hFF;
    dump(0, 3, 0);

    dump(0, 0, 0);

    @(negedge clk);
    abortA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    fill(0);
    dump(0, 2, 1);

    fill(0);
    dump(0, 10, 2);

    // Reset in the middle of data bit 3.
    fill(0);
    memA[0] = 8'h00;
    for (int a = 0; a < 3; a++)
      expq.push_back('{addr: a, data: memA[a]});
    @(negedge clk);
    set_start(0, 1'b1, 3);
    k = cyc + 1;
    @(negedge clk);
    set_start(0, 1'b0, 0);
    while (cyc < k + 1 + RLA + 4 * DA + DA / 2)
      @(negedge clk);
    chk("line_low_before_reset", txA, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_line", txA, 1);
    chk("async_reset_busy", busyA, 0);
    chk("async_reset_addr", addrA, 0);
    chk("async_reset_done", doneA, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    repeat (3) @(negedge clk);
    fill(0);
    dump(0, 2, 0);

    for (int r = 0; r < 3; r++) begin
      fill(0);
      dump(0, int'($urandom_range(1, 4)), 0);
    end

    fill(1);
    dump(1, 20, 0);
    fill(1);
    dump(1, int'($urandom_range(1, 5)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
